alu_cmd_ctrl: RTL
=================

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
- REQ-001 SHALL have parameter OPER_W, default 16: width of ALU operands and results.
- REQ-002 SHALL have parameter BYTE_W, default 8: width of the byte stream on both rx and tx.
- REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
- REQ-004 SHALL have port RST, input, 1: reset, asynchronous and active-high.
- REQ-005 SHALL have port rx_data, input, BYTE_W: command byte; rx_valid, input, 1: one-cycle strobe, no backpressure.
- REQ-006 SHALL have port busy, output, 1: high outside CMD state.
- REQ-007 SHALL have ports alu_a and alu_b, output, OPER_W: operands; alu_fun, output, 4: function code; alu_en, output, 1: one-cycle issue strobe.
- REQ-008 SHALL have ports arith_out, logic_out, cmp_out, shift_out, input, OPER_W each: ALU results.
- REQ-009 SHALL have ports arith_flag, logic_flag, cmp_flag, shift_flag, input, 1 each: result-valid flags.
- REQ-010 SHALL have ports tx_data, output, BYTE_W; tx_valid, output, 1; tx_ready, input, 1: the result byte stream.

Function
- REQ-011 SHALL accept a 5-byte frame: FUN (bits [3:0]; [7:4] ignored), A_LO, A_HI, B_LO, B_HI.
- REQ-012 SHALL step FSM states CMD, A_LO, A_HI, B_LO, B_HI on each rx_valid; without rx_valid the state holds.
- REQ-013 SHALL, on capture of B_HI, enter EXEC: drive alu_a/alu_b/alu_fun registered and pulse alu_en for exactly one cycle.
- REQ-014 SHALL then enter WAIT and capture the result on the first cycle where any flag is high.
- REQ-015 SHALL select by flag priority when several flags are high: arith > logic > cmp > shift.
- REQ-016 SHALL keep alu_a, alu_b and alu_fun stable from EXEC until WAIT exits.
- REQ-017 SHALL send RES_LO then RES_HI; each byte is held on tx_data with tx_valid high until a cycle with tx_ready high, then advances.
- REQ-018 SHALL return to CMD after the last byte completes its handshake.
- REQ-019 SHALL drop rx_valid bytes arriving outside CMD..B_HI and pulse output rx_drop (1 bit) for one cycle per dropped byte.
- REQ-020 SHALL treat results as raw two's-complement bits, with no sign extension or truncation beyond OPER_W.

Reset
- REQ-021 SHALL, on RST high at any time including mid-frame or mid-handshake, immediately force state CMD.
- REQ-022 SHALL, while RST is high, drive alu_a, alu_b, alu_fun, alu_en, tx_data, tx_valid, busy and rx_drop to 0 and clear the captured result.
- REQ-023 SHALL, after RST deasserts, accept FUN on the first rx_valid and lose any partial frame.

Configuration
- REQ-024 SHALL, with macro ALU_CMD_STATUS_EN defined, append a third byte STATUS = {4'b0, arith_flag, logic_flag, cmp_flag, shift_flag} as captured, sent with the same handshake.
- REQ-025 SHALL, without ALU_CMD_STATUS_EN, send exactly two bytes per frame.

Structure
- REQ-026 SHALL place the FSM state enum, frame length constants and flag-priority encoding in shared package alu_cmd_pkg.
- REQ-027 SHALL implement the tx byte-hold/handshake as sub-module alu_cmd_tx_ser; frame parsing and the FSM stay in the top.

Verification
- REQ-028 SHALL test frame 00,FF,0F,01,00 with a registered ALU model -> alu_en one pulse, A=0x0FFF, B=0x0001; tx 0x00 then 0x10.
- REQ-029 SHALL test frame 0A,09,00,05,00 (cmp) with cmp_flag=1, cmp_out=0x0002 -> tx 0x02, 0x00.
- REQ-030 SHALL test tx_ready low for 5 cycles during RES_LO -> tx_data stable and tx_valid high for all 5 cycles; no byte lost or duplicated.
- REQ-031 SHALL test rx_valid in WAIT -> rx_drop pulses once, and the next frame decodes correctly.
- REQ-032 SHALL test RST pulsed after A_HI, then full frame 04,04,00,08,00 -> tx 0x00, 0x00; all outputs 0 during reset.
- REQ-033 SHALL test ALU_CMD_STATUS_EN with arith_flag and logic_flag both high -> arith_out selected; STATUS byte 0x0C.

Source files
------------

// File: rtl/alu_cmd_pkg.sv
// Shared types for alu_cmd_ctrl: FSM states, frame lengths, result-flag priority.
// ALU_CMD_STATUS_EN adds a STATUS byte to the tx frame.
package alu_cmd_pkg;

  typedef enum logic [2:0] {
    ST_CMD, ST_A_LO, ST_A_HI, ST_B_LO, ST_B_HI, ST_EXEC, ST_WAIT, ST_TX
  } state_e;

  localparam int RX_FRAME_LEN = 5;
`ifdef ALU_CMD_STATUS_EN
  localparam int TX_FRAME_LEN = 3;
`else
  localparam int TX_FRAME_LEN = 2;
`endif

  typedef enum logic [2:0] {
    SEL_NONE, SEL_ARITH, SEL_LOGIC, SEL_CMP, SEL_SHIFT
  } res_sel_e;

  // flags packed as {arith, logic, cmp, shift}; highest bit wins
  function automatic res_sel_e flag_sel(input logic [3:0] flags);
    if (flags[3])      return SEL_ARITH;
    else if (flags[2]) return SEL_LOGIC;
    else if (flags[1]) return SEL_CMP;
    else if (flags[0]) return SEL_SHIFT;
    else               return SEL_NONE;
  endfunction

endpackage

// File: rtl/alu_cmd_tx_ser.sv
// Result-byte serializer: presents NBYTES bytes in order, each held with
// o_tx_valid until i_tx_ready; o_done marks the final handshake cycle.
module alu_cmd_tx_ser
  import alu_cmd_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int NBYTES = TX_FRAME_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [NBYTES-1:0][BYTE_W-1:0] i_frame,
  output logic [BYTE_W-1:0]             o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic                          o_done
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [IDX_W-1:0]  r_idx;
  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic              w_hs;
  logic              w_last;

  assign w_hs   = r_valid & i_tx_ready;
  assign w_last = (r_idx == IDX_W'(NBYTES - 1));
  assign o_done = w_hs & w_last;

  assign o_tx_data  = r_data;
  assign o_tx_valid = r_valid;

  // i_frame must stay stable while the frame is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_start) begin
      r_idx   <= '0;
      r_data  <= i_frame[0];
      r_valid <= 1'b1;
    end else if (w_hs) begin
      if (w_last) begin
        r_idx   <= '0;
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx  <= r_idx + 1'b1;
        r_data <= i_frame[r_idx + 1'b1];
      end
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-stream ALU command controller: parses FUN/A/B frames, issues one ALU op,
// returns RES_LO/RES_HI (plus STATUS when ALU_CMD_STATUS_EN is defined).
module alu_cmd_ctrl
  import alu_cmd_pkg::*;
#(
  parameter int OPER_W = 16,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_drop,
  output logic              busy,
  output logic [OPER_W-1:0] alu_a,
  output logic [OPER_W-1:0] alu_b,
  output logic [3:0]        alu_fun,
  output logic              alu_en,
  input  logic [OPER_W-1:0] arith_out,
  input  logic [OPER_W-1:0] logic_out,
  input  logic [OPER_W-1:0] cmp_out,
  input  logic [OPER_W-1:0] shift_out,
  input  logic              arith_flag,
  input  logic              logic_flag,
  input  logic              cmp_flag,
  input  logic              shift_flag,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int RES_EXT_W = 2 * BYTE_W;

  state_e            r_state;
  logic [3:0]        r_fun;
  logic [BYTE_W-1:0] r_a_lo, r_a_hi, r_b_lo;
  logic [OPER_W-1:0] r_alu_a, r_alu_b;
  logic [3:0]        r_alu_fun;
  logic              r_alu_en;
  logic              r_busy;
  logic              r_rx_drop;
  logic [OPER_W-1:0] r_res;
  logic [3:0]        r_flags;
  logic              r_tx_start;

  logic [3:0]                             w_flags;
  logic [OPER_W-1:0]                      w_res_sel;
  logic [RES_EXT_W-1:0]                   w_res_ext;
  logic [TX_FRAME_LEN-1:0][BYTE_W-1:0]    w_tx_frame;
  logic                                   w_tx_done;

  assign w_flags = {arith_flag, logic_flag, cmp_flag, shift_flag};

  always_comb begin
    w_res_sel = '0;
    case (flag_sel(w_flags))
      SEL_ARITH: w_res_sel = arith_out;
      SEL_LOGIC: w_res_sel = logic_out;
      SEL_CMP:   w_res_sel = cmp_out;
      SEL_SHIFT: w_res_sel = shift_out;
      default:   w_res_sel = '0;
    endcase
  end

  always_comb begin
    w_res_ext     = RES_EXT_W'(r_res);
    w_tx_frame    = '0;
    w_tx_frame[0] = w_res_ext[BYTE_W-1:0];
    w_tx_frame[1] = w_res_ext[RES_EXT_W-1:BYTE_W];
`ifdef ALU_CMD_STATUS_EN
    w_tx_frame[2] = BYTE_W'(r_flags);
`endif
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state    <= ST_CMD;
      r_fun      <= '0;
      r_a_lo     <= '0;
      r_a_hi     <= '0;
      r_b_lo     <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_fun  <= '0;
      r_alu_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_drop  <= 1'b0;
      r_res      <= '0;
      r_flags    <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_alu_en   <= 1'b0;
      r_tx_start <= 1'b0;
      r_rx_drop  <= rx_valid && (r_state inside {ST_EXEC, ST_WAIT, ST_TX});
      case (r_state)
        ST_CMD: if (rx_valid) begin
          r_fun   <= rx_data[3:0];
          r_busy  <= 1'b1;
          r_state <= ST_A_LO;
        end
        ST_A_LO: if (rx_valid) begin
          r_a_lo  <= rx_data;
          r_state <= ST_A_HI;
        end
        ST_A_HI: if (rx_valid) begin
          r_a_hi  <= rx_data;
          r_state <= ST_B_LO;
        end
        ST_B_LO: if (rx_valid) begin
          r_b_lo  <= rx_data;
          r_state <= ST_B_HI;
        end
        // operands stay registered until the next frame reaches this point
        ST_B_HI: if (rx_valid) begin
          r_alu_a   <= OPER_W'({r_a_hi, r_a_lo});
          r_alu_b   <= OPER_W'({rx_data, r_b_lo});
          r_alu_fun <= r_fun;
          r_alu_en  <= 1'b1;
          r_state   <= ST_EXEC;
        end
        ST_EXEC: r_state <= ST_WAIT;
        ST_WAIT: if (|w_flags) begin
          r_res      <= w_res_sel;
          r_flags    <= w_flags;
          r_tx_start <= 1'b1;
          r_state    <= ST_TX;
        end
        ST_TX: if (w_tx_done) begin
          r_busy  <= 1'b0;
          r_state <= ST_CMD;
        end
        default: r_state <= ST_CMD;
      endcase
    end
  end

  alu_cmd_tx_ser #(
    .BYTE_W (BYTE_W),
    .NBYTES (TX_FRAME_LEN)
  ) u_tx_ser (
    .clk        (clk),
    .rst        (RST),
    .i_start    (r_tx_start),
    .i_frame    (w_tx_frame),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_done     (w_tx_done)
  );

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_fun = r_alu_fun;
  assign alu_en  = r_alu_en;
  assign busy    = r_busy;
  assign rx_drop = r_rx_drop;

endmodule
